// File: rtl/vend_uart_ctrl.sv
// Vending-machine command sequencer: decodes UART command bytes into credit,
// item selection, dispenser handshake and change. Optional macro: VEND_TIMEOUT_EN.
module vend_uart_ctrl #(
    parameter logic [7:0]  PRICE          = 8'd65,
    parameter logic [7:0]  MAX_CREDIT     = 8'd200,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       vend_req_o,
    output logic [1:0] vend_item_o,
    input  logic       vend_ack_i,
    output logic [7:0] change_o,
    output logic       change_valid_o,
    output logic [7:0] credit_o,
    output logic       busy_o,
    output logic       reject_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CREDIT    = 2'd1,
        VEND_WAIT = 2'd2,
        CHANGE    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic       vend_req_q, vend_req_d;
    logic [1:0] vend_item_q, vend_item_d;
    logic [7:0] change_q, change_d;
    logic       change_valid_q, change_valid_d;
    logic       reject_q, reject_d;
    logic       busy_q, busy_d;

    logic       is_coin, is_sel, is_cancel;
    logic [7:0] coin_val;
    logic [1:0] sel_item;
    logic [8:0] coin_sum;
    logic       coin_fits;
    logic       timeout_hit;

    always_comb begin
        is_coin   = 1'b0;
        is_sel    = 1'b0;
        is_cancel = 1'b0;
        coin_val  = 8'd0;
        sel_item  = 2'd0;
        case (rx_data_i)
            8'h6e: begin is_coin = 1'b1; coin_val = 8'd5;  end
            8'h64: begin is_coin = 1'b1; coin_val = 8'd10; end
            8'h71: begin is_coin = 1'b1; coin_val = 8'd25; end
            8'h31: begin is_sel = 1'b1; sel_item = 2'd0; end
            8'h32: begin is_sel = 1'b1; sel_item = 2'd1; end
            8'h33: begin is_sel = 1'b1; sel_item = 2'd2; end
            8'h34: begin is_sel = 1'b1; sel_item = 2'd3; end
            8'h63: is_cancel = 1'b1;
            default: ;
        endcase
    end

    // Nine-bit sum so a coin near the ceiling cannot wrap into a small credit.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = (coin_sum <= {1'b0, MAX_CREDIT});

`ifdef VEND_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = (state_q == CREDIT) && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        tmo_cnt_d = 32'd0;
        if (state_q == CREDIT && !rx_valid_i && !timeout_hit) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt_q <= 32'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_req_d     = vend_req_q;
        vend_item_d    = vend_item_q;
        change_d       = 8'd0;
        change_valid_d = 1'b0;
        reject_d       = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (rx_valid_i) begin
                    if (is_coin) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[7:0];
                            state_d  = CREDIT;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (is_sel) begin
                        if (credit_q >= PRICE) begin
                            credit_d    = credit_q - PRICE;
                            vend_item_d = sel_item;
                            vend_req_d  = 1'b1;
                            state_d     = VEND_WAIT;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (is_cancel && credit_q != 8'd0) begin
                        state_d        = CHANGE;
                        change_d       = credit_q;
                        change_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d        = CHANGE;
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                end
            end
            VEND_WAIT: begin
                // Bytes are dropped here; only the acknowledge advances the state.
                if (vend_ack_i) begin
                    vend_req_d = 1'b0;
                    if (credit_q != 8'd0) begin
                        state_d        = CHANGE;
                        change_d       = credit_q;
                        change_valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CHANGE: begin
                credit_d = 8'd0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == VEND_WAIT) || (state_d == CHANGE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            credit_q       <= 8'd0;
            vend_req_q     <= 1'b0;
            vend_item_q    <= 2'd0;
            change_q       <= 8'd0;
            change_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_req_q     <= vend_req_d;
            vend_item_q    <= vend_item_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            reject_q       <= reject_d;
            busy_q         <= busy_d;
        end
    end

    assign vend_req_o     = vend_req_q;
    assign vend_item_o    = vend_item_q;
    assign change_o       = change_q;
    assign change_valid_o = change_valid_q;
    assign credit_o       = credit_q;
    assign busy_o         = busy_q;
    assign reject_o       = reject_q;

endmodule

// File: doc/vend_uart_ctrl.md
# vend_uart_ctrl

Command sequencer for the vending machine, fed by the UART receive path. It consumes one-cycle byte strobes from the receiver and tracks inserted credit from coin command bytes. It accepts item selections, drives a request/acknowledge handshake to the dispenser and returns change. It sits between the UART receiver (byte plus valid strobe) and the dispenser/coin-return logic.

## Interface
Parameters:
- PRICE, 8'd65, price of every item in cents.
- MAX_CREDIT, 8'd200, credit ceiling; a coin that would exceed it is rejected.
- TIMEOUT_CYCLES, 32'd1_000_000_000, idle cycles with credit before auto-refund (10 s at 100 MHz).

Ports:
- clk, in, 1, system clock (100 MHz).
- reset, in, 1, asynchronous, active-high; clears all state.
- rx_data, in, 8, received ASCII byte; valid only while rx_valid=1.
- rx_valid, in, 1, one-cycle strobe per received byte.
- vend_req, out, 1, dispense request; level, held until vend_ack.
- vend_item, out, 2, item index 0..3; stable while vend_req=1.
- vend_ack, in, 1, dispenser acknowledge; one-cycle pulse.
- change, out, 8, refund amount in cents; valid when change_valid=1.
- change_valid, out, 1, one-cycle refund strobe.
- credit, out, 8, current credit in cents.
- busy, out, 1, high in VEND_WAIT and CHANGE.
- reject, out, 1, one-cycle pulse for a refused coin or selection.

## Operation
- Command bytes (lowercase only): 'n' = +5, 'd' = +10, 'q' = +25; '1'..'4' = select item 0..3; 'c' = cancel/refund. Any other byte is ignored with no reject.
- States:
  - IDLE: credit = 0.
  - CREDIT: credit > 0.
  - VEND_WAIT.
  - CHANGE.
- IDLE/CREDIT coin byte:
  - If credit + value ≤ MAX_CREDIT, add it to credit and go to CREDIT.
  - Otherwise pulse reject; credit is unchanged.
  - The sum is computed 9 bits wide; no wrap.
- IDLE/CREDIT selection:
  - If credit ≥ PRICE: credit -= PRICE, latch vend_item, assert vend_req, go to VEND_WAIT.
  - If credit < PRICE: pulse reject; state is unchanged.
- IDLE/CREDIT 'c':
  - With credit > 0, go to CHANGE.
  - With credit = 0, no effect.
- VEND_WAIT:
  - vend_ack deasserts vend_req.
  - If remaining credit > 0, go to CHANGE; otherwise go to IDLE.
  - Every rx_valid byte is dropped silently.
- CHANGE: lasts one cycle.
  - change = credit and change_valid = 1.
  - credit is cleared; go to IDLE.
  - Bytes arriving in this cycle are dropped.
- vend_ack outside VEND_WAIT is ignored.

## Timing
- Reset values: every output is 0; state = IDLE; timeout counter = 0.
- Reset asserted mid-operation aborts immediately; credit is lost and no change is emitted.
- Latency:
  - rx_valid sampled at edge N: credit, reject, vend_req and vend_item update at edge N (visible from cycle N+1). This is one cycle of latency.
  - vend_ack sampled at edge M: vend_req = 0 from cycle M+1, and CHANGE occupies cycle M+1 if remaining credit > 0.
  - 'c' at edge N: change_valid is high during cycle N+1 and credit = 0 from cycle N+2.
- rx_valid and vend_ack in the same cycle in VEND_WAIT: the ack is processed and the byte is dropped.
- Back-to-back rx_valid on consecutive cycles must each be processed outside busy states.
- busy is a registered decode of the state; there is no combinational path from any input to any output.

## Configuration
- VEND_TIMEOUT_EN defined:
  - In CREDIT, a 32-bit counter increments each cycle and clears on any rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, the FSM enters CHANGE on the next edge and refunds the full credit.
  - The counter is held at 0 outside CREDIT.
- VEND_TIMEOUT_EN undefined: the counter logic is absent and credit is held indefinitely.

## Test plan
- Reset, then 'q','q','q' → credit 25/50/75; '2' → vend_req=1, vend_item=1, credit=10. vend_ack → vend_req=0 next cycle, then a change_valid pulse with change=10, then credit=0 and state IDLE.
- 'q','q','d' (60) then '1' → reject pulse; credit stays 60. 'c' → change=60, then credit=0.
- Eight 'q' (200) then 'n' → reject, credit=200. A ninth 'q' → reject.
- Selection accepted with exact credit 65 → on vend_ack, return to IDLE with no change_valid. 'q' sent during VEND_WAIT → dropped, credit unchanged.
- VEND_TIMEOUT_EN with TIMEOUT_CYCLES=16: 'd' then silence → change=10 exactly 16 cycles after the byte edge. A byte at cycle 10 restarts the count. Without the macro → no refund after 1000 cycles.
- Reset asserted during VEND_WAIT with credit 35 → vend_req=0 and credit=0 immediately, no change_valid; a normal transaction afterwards passes.
